// File: rtl/sh_conv_sequencer_pkg.sv
// Shared types for the sample/hold conversion sequencer.
package sh_seq_pkg;

  // Width of the track, settle and conversion-timeout counters.
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    TRACK,
    SETTLE,
    CONVERT,
    RESULT
  } state_e;

endpackage

// File: rtl/sh_conv_sequencer_if.sv
// Channel request, sample/hold, quantiser and result bus of the sequencer.
interface sh_conv_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              enable;
  logic [7:0]        track_cycles;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] ack;
  logic              sample_en;
  logic [CH_W-1:0]   ch_sel;
  logic              conv_start;
  logic              conv_done;
  logic [DATA_W-1:0] conv_data;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [CH_W-1:0]   res_ch;
  logic              busy;
  logic              err_tmo;

  // Sequencer side.
  modport master (
    input  enable, track_cycles, req, conv_done, conv_data, res_ready,
    output ack, sample_en, ch_sel, conv_start, res_valid, res_data, res_ch,
           busy, err_tmo
  );

  // Environment side: channel triggers, datapath and result consumer.
  modport slave (
    output enable, track_cycles, req, conv_done, conv_data, res_ready,
    input  ack, sample_en, ch_sel, conv_start, res_valid, res_data, res_ch,
           busy, err_tmo
  );

endinterface

// File: rtl/sh_conv_sequencer_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer.
module sh_rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [CH_W-1:0]   gnt_idx_o,
  output logic              gnt_vld_o
);

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    int j;
    j         = 0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (req_i[j]) begin
        gnt_idx_o = CH_W'(j);
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sh_conv_sequencer.sv
// Time-shares one sample/hold + quantiser among NUM_CH channels:
// round-robin grant, track window, settle, convert, hand off the result.
module sh_conv_sequencer
  import sh_seq_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int SETTLE_CYC = 2,
  parameter int CONV_TMO   = 255
) (
  input logic              clk,
  input logic              reset,
  sh_conv_sequencer_if.master bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  trk_len_q, trk_len_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic              sample_en_q, sample_en_d;
  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic              conv_start_q, conv_start_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic              busy_q, busy_d;
  logic              err_tmo_q, err_tmo_d;

  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_vld;

  sh_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Next-state and registered-output logic; every output is a register.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    trk_len_d    = trk_len_q;
    ptr_d        = ptr_q;
    ack_d        = '0;
    sample_en_d  = sample_en_q;
    ch_sel_d     = ch_sel_q;
    conv_start_d = 1'b0;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_ch_d     = res_ch_q;
    err_tmo_d    = err_tmo_q;

    if (!bus.enable) begin
      // Abort: drop any sequence in flight and any unread result.
      state_d     = IDLE;
      cnt_d       = '0;
      sample_en_d = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            state_d     = TRACK;
            ack_d       = NUM_CH'(1) << gnt_idx;
            ch_sel_d    = gnt_idx;
            sample_en_d = 1'b1;
            ptr_d       = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
            trk_len_d   = (bus.track_cycles == 8'd0) ? CNT_W'(1) : bus.track_cycles;
            cnt_d       = CNT_W'(1);
          end
        end
        TRACK: begin
          if (cnt_q >= trk_len_q) begin
            state_d     = SETTLE;
            sample_en_d = 1'b0;
            cnt_d       = CNT_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt_q >= CNT_W'(SETTLE_CYC)) begin
            state_d      = CONVERT;
            conv_start_d = 1'b1;
            cnt_d        = CNT_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        CONVERT: begin
          // cnt_q is the 1-based index of the current CONVERT cycle.
          if (bus.conv_done) begin
            state_d     = RESULT;
            res_data_d  = bus.conv_data;
            res_ch_d    = ch_sel_q;
            res_valid_d = 1'b1;
            cnt_d       = '0;
          end else if (cnt_q >= CNT_W'(CONV_TMO)) begin
            state_d   = IDLE;
            err_tmo_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      trk_len_q    <= '0;
      ptr_q        <= '0;
      ack_q        <= '0;
      sample_en_q  <= 1'b0;
      ch_sel_q     <= '0;
      conv_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_ch_q     <= '0;
      busy_q       <= 1'b0;
      err_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      trk_len_q    <= trk_len_d;
      ptr_q        <= ptr_d;
      ack_q        <= ack_d;
      sample_en_q  <= sample_en_d;
      ch_sel_q     <= ch_sel_d;
      conv_start_q <= conv_start_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_ch_q     <= res_ch_d;
      busy_q       <= busy_d;
      err_tmo_q    <= err_tmo_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.sample_en  = sample_en_q;
  assign bus.ch_sel     = ch_sel_q;
  assign bus.conv_start = conv_start_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_ch     = res_ch_q;
  assign bus.busy       = busy_q;
  assign bus.err_tmo    = err_tmo_q;

endmodule

// File: tb/tb_sh_conv_sequencer.sv
// Directed bench for sh_conv_sequencer (NUM_CH=4, SETTLE_CYC=2, CONV_TMO=255).
module tb_sh_conv_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sh_conv_sequencer_if #(.NUM_CH(4), .DATA_W(16)) bus ();

  sh_conv_sequencer #(
    .NUM_CH(4), .DATA_W(16), .SETTLE_CYC(2), .CONV_TMO(255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Observations gathered by do_seq.
  logic [3:0]  o_ack;
  int          o_ack_cyc, o_ack_n, o_se_n, o_se_last, o_st_cyc, o_st_n;
  int          o_res_cyc, o_idle_cyc;
  logic [15:0] o_res_d;
  logic [1:0]  o_res_c;
  bit          o_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.enable       = 1'b1;
    bus.req          = '0;
    bus.track_cycles = '0;
    bus.conv_done    = 1'b0;
    bus.conv_data    = '0;
    bus.res_ready    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Drives one request set; cycle 0 is the current cycle. conv_done is
  // pulsed dly cycles after conv_start is seen (dly<0: never). Stops at
  // the first res_valid or when the block drops busy after conv_start.
  task automatic do_seq(input logic [3:0] rq, input logic [7:0] tc,
                        input int dly, input logic [15:0] data, input logic rdy);
    int cyc;
    o_ack = '0; o_ack_cyc = -1; o_ack_n = 0; o_se_n = 0; o_se_last = -1;
    o_st_cyc = -1; o_st_n = 0; o_res_cyc = -1; o_idle_cyc = -1;
    o_res_d = '0; o_res_c = '0; o_done = 1'b0;
    bus.req = rq; bus.track_cycles = tc; bus.res_ready = rdy;
    bus.conv_data = data; bus.conv_done = 1'b0;
    cyc = 0;
    while (cyc < 600 && !o_done) begin
      tick();
      cyc++;
      if (bus.ack != 4'b0) begin
        if (o_ack_cyc < 0) begin
          o_ack = bus.ack;
          o_ack_cyc = cyc;
        end
        o_ack_n++;
        bus.req = bus.req & ~bus.ack;
      end
      if (bus.sample_en) begin
        o_se_n++;
        o_se_last = cyc;
      end
      if (bus.conv_start) begin
        if (o_st_cyc < 0) o_st_cyc = cyc;
        o_st_n++;
      end
      if (bus.res_valid) begin
        o_res_cyc = cyc;
        o_res_d = bus.res_data;
        o_res_c = bus.res_ch;
        o_done = 1'b1;
      end else if (o_st_cyc >= 0 && !bus.busy) begin
        o_idle_cyc = cyc;
        o_done = 1'b1;
      end
      bus.conv_done = (dly >= 0 && o_st_cyc >= 0 && cyc == o_st_cyc + dly);
    end
    bus.conv_done = 1'b0;
    checks++;
    if (!o_done) begin
      errors++;
      $display("FAIL seq_budget: sequence still running after %0d cycles, required completion", cyc);
    end
  endtask

  task automatic test_reset();
    logic [28:0] snap;
    reset = 1'b1;
    bus.enable = 1'b1; bus.req = 4'b1111; bus.track_cycles = 8'd4;
    bus.conv_done = 1'b1; bus.conv_data = 16'hFFFF; bus.res_ready = 1'b1;
    tick();
    tick();
    snap = {bus.ack, bus.sample_en, bus.ch_sel, bus.conv_start, bus.res_valid,
            bus.res_data, bus.res_ch, bus.busy, bus.err_tmo};
    checks++;
    if (snap !== 29'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", snap);
    end
    bus.req = '0; bus.conv_done = 1'b0; bus.res_ready = 1'b0;
    reset = 1'b0;
    tick();
    snap = {bus.ack, bus.sample_en, bus.ch_sel, bus.conv_start, bus.res_valid,
            bus.res_data, bus.res_ch, bus.busy, bus.err_tmo};
    checks++;
    if (snap !== 29'h0) begin
      errors++;
      $display("FAIL reset_idle: got %h, required 0", snap);
    end
  endtask

  task automatic test_single();
    do_reset();
    do_seq(4'b0100, 8'd3, 4, 16'hA5A5, 1'b0);
    checks++;
    if (o_ack !== 4'b0100 || o_ack_cyc != 1 || o_ack_n != 1) begin
      errors++;
      $display("FAIL single_ack: ack=%b cyc=%0d n=%0d, required 0100 cyc=1 n=1", o_ack, o_ack_cyc, o_ack_n);
    end
    checks++;
    if (o_se_n != 3 || o_se_last != 3) begin
      errors++;
      $display("FAIL single_track: sample_en cycles=%0d last=%0d, required 3 last=3", o_se_n, o_se_last);
    end
    checks++;
    if (o_st_cyc != o_se_last + 3 || o_st_n != 1) begin
      errors++;
      $display("FAIL single_settle: conv_start cyc=%0d n=%0d, required cyc=%0d n=1", o_st_cyc, o_st_n, o_se_last + 3);
    end
    checks++;
    if (o_res_cyc != 11 || o_res_d !== 16'hA5A5 || o_res_c !== 2'd2) begin
      errors++;
      $display("FAIL single_result: cyc=%0d data=%h ch=%0d, required cyc=11 data=a5a5 ch=2", o_res_cyc, o_res_d, o_res_c);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: res_valid=%b busy=%b, required 0 0", bus.res_valid, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_ch [5] = '{0, 1, 2, 3, 0};
    int grants, results;
    do_reset();
    grants = 0; results = 0;
    bus.req = 4'b1111; bus.track_cycles = 8'd1; bus.res_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && results < 5; cyc++) begin
      tick();
      if (bus.ack != 4'b0) begin
        if (grants < 5) begin
          checks++;
          if (bus.ack !== (4'b0001 << exp_ch[grants])) begin
            errors++;
            $display("FAIL rr_grant%0d: ack=%b, required %b", grants, bus.ack, 4'b0001 << exp_ch[grants]);
          end
        end
        grants++;
      end
      if (bus.res_valid) begin
        checks++;
        if (bus.res_ch !== 2'(exp_ch[results]) || bus.res_data !== 16'hC0C0 + 16'(exp_ch[results])) begin
          errors++;
          $display("FAIL rr_result%0d: ch=%0d data=%h, required ch=%0d data=%h", results, bus.res_ch, bus.res_data, exp_ch[results], 16'hC0C0 + 16'(exp_ch[results]));
        end
        results++;
      end
      bus.conv_done = bus.conv_start;
      if (grants >= 1 && grants <= 5) bus.conv_data = 16'hC0C0 + 16'(exp_ch[grants-1]);
    end
    bus.conv_done = 1'b0;
    bus.req = '0;
    checks++;
    if (results != 5) begin
      errors++;
      $display("FAIL rr_count: results=%0d, required 5", results);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_seq(4'b0100, 8'd2, 0, 16'h3C3C, 1'b0);
    checks++;
    if (o_res_cyc != 6) begin
      errors++;
      $display("FAIL bp_latency: res_valid at cycle %0d, required 6", o_res_cyc);
    end
    bus.req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({bus.res_valid, bus.res_data, bus.res_ch, bus.ack} !== {1'b1, 16'h3C3C, 2'd2, 4'b0000}) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h ch=%0d ack=%b, required 1 3c3c 2 0000", i, bus.res_valid, bus.res_data, bus.res_ch, bus.ack);
      end
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: valid=%b ack=%b busy=%b, required 0 0000 0", bus.res_valid, bus.ack, bus.busy);
    end
    tick();
    checks++;
    if (bus.ack !== 4'b0001 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_grant: ack=%b busy=%b, required 0001 1", bus.ack, bus.busy);
    end
    bus.req = '0;
  endtask

  task automatic test_track_zero();
    do_reset();
    do_seq(4'b1000, 8'd0, 0, 16'h0F0F, 1'b1);
    checks++;
    if (o_se_n != 1) begin
      errors++;
      $display("FAIL tz_track: sample_en cycles=%0d, required 1", o_se_n);
    end
    checks++;
    if (o_res_cyc != 5 || o_res_c !== 2'd3 || o_res_d !== 16'h0F0F) begin
      errors++;
      $display("FAIL tz_result: cyc=%0d ch=%0d data=%h, required 5 3 0f0f", o_res_cyc, o_res_c, o_res_d);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    do_seq(4'b0010, 8'd1, -1, 16'h0000, 1'b1);
    checks++;
    if (o_st_cyc != 4 || o_idle_cyc - o_st_cyc != 255) begin
      errors++;
      $display("FAIL tmo_length: start=%0d idle=%0d, required start=4 idle=259", o_st_cyc, o_idle_cyc);
    end
    checks++;
    if (bus.err_tmo !== 1'b1 || bus.busy !== 1'b0 || o_res_cyc != -1) begin
      errors++;
      $display("FAIL tmo_flag: err_tmo=%b busy=%b res_cyc=%0d, required 1 0 -1", bus.err_tmo, bus.busy, o_res_cyc);
    end
    bus.conv_data = 16'hDEAD;
    bus.conv_done = 1'b1;
    tick();
    bus.conv_done = 1'b0;
    tick();
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_stray_done: res_valid=%b busy=%b, required 0 0", bus.res_valid, bus.busy);
    end
    do_seq(4'b0001, 8'd1, 0, 16'h1234, 1'b1);
    checks++;
    if (o_res_d !== 16'h1234 || o_res_c !== 2'd0 || bus.err_tmo !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky: data=%h ch=%0d err_tmo=%b, required 1234 0 1", o_res_d, o_res_c, bus.err_tmo);
    end
    tick();
  endtask

  task automatic test_abort();
    logic [28:0] snap;
    bus.req = 4'b0100; bus.track_cycles = 8'd5; bus.res_ready = 1'b0;
    tick();
    checks++;
    if (bus.ack !== 4'b0100 || bus.sample_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_grant: ack=%b sample_en=%b, required 0100 1", bus.ack, bus.sample_en);
    end
    bus.req = '0;
    tick();
    bus.enable = 1'b0;
    tick();
    checks++;
    if (bus.sample_en !== 1'b0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.err_tmo !== 1'b1) begin
      errors++;
      $display("FAIL abort_enable: sample_en=%b busy=%b res_valid=%b err_tmo=%b, required 0 0 0 1", bus.sample_en, bus.busy, bus.res_valid, bus.err_tmo);
    end
    bus.enable = 1'b1;
    do_seq(4'b1001, 8'd1, 0, 16'hBEEF, 1'b0);
    bus.req = '0;
    checks++;
    if (o_ack !== 4'b1000 || o_res_d !== 16'hBEEF || o_res_c !== 2'd3) begin
      errors++;
      $display("FAIL abort_ptr_kept: ack=%b data=%h ch=%0d, required 1000 beef 3", o_ack, o_res_d, o_res_c);
    end
    reset = 1'b1;
    tick();
    snap = {bus.ack, bus.sample_en, bus.ch_sel, bus.conv_start, bus.res_valid,
            bus.res_data, bus.res_ch, bus.busy, bus.err_tmo};
    checks++;
    if (snap !== 29'h0) begin
      errors++;
      $display("FAIL abort_reset: outputs=%h, required 0", snap);
    end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_track_zero();
    test_timeout();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sh_conv_sequencer.md
Name: sh_conv_sequencer

Overview:
Time-shares the single sample_hold block and its downstream quantiser among NUM_CH requesting channels. The block arbitrates requests round-robin and drives the S/H sample_en for a programmable track window. It waits a fixed settle interval, issues a conversion start, collects the result, and presents the result with its channel tag on a valid/ready interface. It sits between the channel trigger logic and the sample_hold/quantiser datapath.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
DATA_W, 16, conversion result width
SETTLE_CYC, 2, hold-settle cycles between sample_en falling and conv_start (1..7)
CONV_TMO, 255, max cycles to wait for conv_done before abort (1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  block enable; low forces abort to IDLE
track_cycles  in  8  track window length in cycles; 0 treated as 1
req  in  NUM_CH  per-channel level request, held until ack
ack  out  NUM_CH  one-hot one-cycle grant pulse
sample_en  out  1  to sample_hold sample_en
ch_sel  out  $clog2(NUM_CH)  channel currently owning S/H (input mux select)
conv_start  out  1  one-cycle quantiser start pulse
conv_done  in  1  quantiser completion strobe
conv_data  in  DATA_W  quantiser result, valid with conv_done
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_data  out  DATA_W  result value
res_ch  out  $clog2(NUM_CH)  channel tag of result
busy  out  1  high in any state except IDLE
err_tmo  out  1  sticky conversion-timeout flag; cleared only by reset

Behaviour:
- Reset values: all outputs 0, state IDLE, RR pointer 0, counters 0.
- All outputs are registered.
- FSM states are IDLE, TRACK, SETTLE, CONVERT, RESULT.
- IDLE:
  - If enable and |req, grant the first set req bit at or after the RR pointer, wrapping.
  - Next cycle: state TRACK, ack[g]=1 for exactly that cycle, ch_sel=g, sample_en=1, RR pointer = g+1 mod NUM_CH.
- TRACK:
  - sample_en held high for max(track_cycles,1) cycles, counted from the first TRACK cycle; track_cycles is sampled at grant.
  - Then SETTLE with sample_en=0.
- SETTLE: SETTLE_CYC cycles with sample_en=0, then CONVERT.
- CONVERT:
  - conv_start=1 in the first CONVERT cycle only.
  - Wait for conv_done. On conv_done, latch conv_data into res_data and ch_sel into res_ch, then go to RESULT with res_valid=1 next cycle.
  - conv_done in the same cycle as conv_start is accepted.
  - conv_done outside CONVERT is ignored.
- Timeout: if CONV_TMO cycles elapse in CONVERT without conv_done, set err_tmo=1, return to IDLE, and produce no result.
- RESULT:
  - res_valid stays high and res_data/res_ch stay stable until res_ready.
  - On res_valid&&res_ready: res_valid=0 next cycle, state IDLE.
  - Arbitration of the next request occurs in the following IDLE cycle, so minimum IDLE dwell is 1 cycle.
- Minimum latency from req to res_valid, with conv_done arriving together with conv_start: 1 (grant) + T + SETTLE_CYC + 1 cycles.
- Requests arriving mid-sequence are not lost; they are evaluated in the next IDLE.
- A req bit dropped before grant is simply not granted.
- enable low in any state: next cycle IDLE, sample_en=0, res_valid=0, any pending result discarded. The RR pointer is kept. err_tmo is unchanged.
- reset asserted mid-operation: same as the reset values above, including err_tmo=0.
- ch_sel keeps its last value in IDLE.

Decomposition:
- Package sh_seq_pkg holds the state enum typedef (IDLE, TRACK, SETTLE, CONVERT, RESULT) and the localparam for the counter width (8).
- One sub-module: sh_rr_arbiter. Inputs: req, pointer. Outputs: combinational grant index and grant-valid.
- The FSM, counters and result register stay in the top.

Test Plan:
1. Single request, req=4'b0100, track_cycles=3, conv_done 4 cycles after conv_start with conv_data=16'hA5A5 -> ack=4'b0100 for 1 cycle; sample_en high exactly 3 cycles; conv_start exactly SETTLE_CYC cycles after sample_en falls; res_valid with res_data=A5A5, res_ch=2.
2. All four req held high, res_ready=1, instant conv_done -> grants in order 0,1,2,3,0; ack is one-hot each time; no result lost.
3. Backpressure: res_ready=0 for 10 cycles -> res_valid, res_data and res_ch stable; the new req=4'b0001 is not granted until one cycle after the handshake.
4. Timeout: conv_done never arrives -> after 255 CONVERT cycles, err_tmo=1, busy=0, no res_valid; err_tmo stays set after the next good conversion.
5. track_cycles=0 -> sample_en high for exactly 1 cycle.
6. Abort: enable dropped during TRACK, then reset asserted during RESULT -> next cycle IDLE with sample_en=0 and res_valid=0; after reset, all outputs 0 and err_tmo=0.
